// File: rtl/rstseq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rstseq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_e;

  // All-ones value of a counter that is `width` bits wide.
  function automatic logic [63:0] CNT_SAT(input int unsigned width);
    if (width >= 64) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

  // Bits needed to count 0..n-1; never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rstseq_debounce.sv
// Persistence filter for the registered reset request. Used only when
// RSTSEQ_DEBOUNCE_EN is defined.
module rstseq_debounce
  import rstseq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sys_reset_q,
  output logic abort_req
);

  localparam int unsigned RUN_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);

  logic [RUN_W-1:0] run_q, run_d;

  always_comb begin
    run_d = '0;
    if (sys_reset_q) run_d = (run_q == RUN_LAST) ? run_q : run_q + 1'b1;
  end

  // run_q holds the preceding consecutive high cycles, so this fires on the Nth.
  assign abort_req = sys_reset_q && (run_q == RUN_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) run_q <= '0;
    else        run_q <= run_d;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Stretches sys_reset to a minimum hold, then releases staged active-low resets.
// Optional RSTSEQ_DEBOUNCE_EN filters short abort pulses in RELEASE/RUN.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned STAGE_GAP       = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sys_reset,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  ready,
  output logic [CNT_W-1:0]      reset_count
);

  localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int unsigned GAP_W  = cnt_w(STAGE_GAP);
  localparam int unsigned IDX_W  = cnt_w(NUM_STAGES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CNT_SAT(CNT_W));

  if (NUM_STAGES < 1 || NUM_STAGES > 8 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
      DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("reset_sequencer: parameter out of range");
  end

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  sys_reset_q;
  logic                  abort_req;
  logic [NUM_STAGES-1:0] stage_bit;

`ifdef RSTSEQ_DEBOUNCE_EN
  rstseq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys_reset_q(sys_reset_q),
    .abort_req  (abort_req)
  );
`else
  assign abort_req = sys_reset_q;
`endif

  assign stage_bit = NUM_STAGES'(1) << idx_q;

  always_comb begin
    state_d   = state_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    count_d   = count_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    // HOLD handles a raw high sample itself (restart); only the filtered request aborts and counts.
    if (state_q != HOLD && abort_req) begin
      state_d   = HOLD;
      rst_out_d = '0;
      ready_d   = 1'b0;
      hold_d    = '0;
      gap_d     = '0;
      idx_d     = '0;
      if (count_q != CNT_MAX) count_d = count_q + 1'b1;
    end else begin
      unique case (state_q)
        HOLD: begin
          rst_out_d = '0;
          ready_d   = 1'b0;
          if (sys_reset_q) begin
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            hold_d       = '0;
            gap_d        = '0;
            idx_d        = IDX_W'(1);
            rst_out_d[0] = 1'b1;
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d     = '0;
            rst_out_d = rst_out_q | stage_bit;
            idx_d     = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          rst_out_d = '1;
          ready_d   = 1'b1;
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      rst_out_q   <= '0;
      ready_q     <= 1'b0;
      count_q     <= '0;
      hold_q      <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      sys_reset_q <= sys_reset;
    end
  end

  assign rst_out_n   = rst_out_q;
  assign ready       = ready_q;
  assign reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer against an elapsed-time reference model.
module tb_reset_sequencer;

  localparam int unsigned NS   = 3;
  localparam int unsigned HOLD = 32;
  localparam int unsigned GAP  = 5;
  localparam int unsigned CW   = 8;
`ifdef RSTSEQ_DEBOUNCE_EN
  localparam int unsigned DEB = 4;
`else
  localparam int unsigned DEB = 0;
`endif
  localparam int unsigned PULSE   = (DEB == 0) ? 1 : DEB;
  localparam int unsigned FULL    = HOLD + (NS - 1) * GAP;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sys_reset = 1'b0;
  logic [NS-1:0] rst_out_n;
  logic          ready;
  logic [CW-1:0] reset_count;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_STAGES     (NS),
    .HOLD_CYCLES    (HOLD),
    .STAGE_GAP      (GAP),
    .CNT_W          (CW),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys_reset  (sys_reset),
    .rst_out_n  (rst_out_n),
    .ready      (ready),
    .reset_count(reset_count)
  );

  always #5 clk = ~clk;

  // Model: m_t = edges since the low-hold window started; stage k is released
  // once m_t >= HOLD + k*GAP. A qualified high sample after stage 0 is an abort.
  int unsigned m_t = 0;
  int unsigned m_h = 0;
  int unsigned m_cnt = 0;
  bit          m_sysq = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t = 0; m_h = 0; m_cnt = 0; m_sysq = 1'b1;
    end else begin
      if (m_sysq) begin
        if (m_h < 1000) m_h = m_h + 1;
        if (m_t < HOLD) m_t = 0;
        else if (DEB == 0 || m_h >= DEB) begin
          m_t = 0;
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else if (m_t < 1000000) m_t = m_t + 1;
      end else begin
        m_h = 0;
        if (m_t < 1000000) m_t = m_t + 1;
      end
      m_sysq = sys_reset;
    end
  end

  function automatic logic [NS+CW:0] exp_vec();
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = (m_t >= HOLD + k * GAP);
    return {r, (m_t >= FULL), CW'(m_cnt)};
  endfunction

  function automatic logic [NS+CW:0] got_vec();
    return {rst_out_n, ready, reset_count};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; sys_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rst_out_n !== '0 || ready !== 1'b0 || reset_count !== '0) begin
        errors++;
        $display("FAIL reset i=%0d got rst_out_n=%b ready=%b count=%0d want 000/0/0",
                 i, rst_out_n, ready, reset_count);
      end
    end
  endtask

  task automatic test_startup();
    logic [NS-1:0] want;
    rst_n = 1'b1; sys_reset = 1'b0;
    for (int n = 0; n <= int'(FULL) + 4; n++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL startup n=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
      if (n == HOLD - 1 || n == HOLD || n == HOLD + GAP || n == FULL) begin
        want = (n == HOLD - 1) ? NS'(0) : (n == HOLD) ? NS'(1) : (n == HOLD + GAP) ? NS'(3) : NS'(7);
        checks++;
        if (rst_out_n !== want || ready !== (n == FULL)) begin
          errors++;
          $display("FAIL startup_edge n=%0d got=%b/%b want=%b/%b", n, rst_out_n, ready, want, n == FULL);
        end
      end
    end
  endtask

  task automatic test_run_pulse();
    logic [CW-1:0] saved;
    saved = reset_count;
    sys_reset = 1'b1;
    for (int i = 0; i < int'(PULSE); i++) @(negedge clk);
    sys_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rst_out_n !== '0 || ready !== 1'b0 || reset_count !== CW'(saved + 1)) begin
      errors++;
      $display("FAIL run_pulse got=%b/%b/%0d want 000/0/%0d", rst_out_n, ready, reset_count, saved + 1);
    end
    for (int n = 0; n < int'(FULL) + 3; n++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL run_pulse_seq n=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_hold_glitch();
    logic [CW-1:0] saved;
    sys_reset = 1'b1;
    for (int i = 0; i < int'(PULSE); i++) @(negedge clk);
    sys_reset = 1'b0;
    for (int i = 0; i < int'(HOLD) - 8; i++) @(negedge clk);
    saved = reset_count;
    sys_reset = 1'b1;
    @(negedge clk);
    sys_reset = 1'b0;
    for (int n = 0; n <= int'(HOLD) + 2; n++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec() || reset_count !== saved ||
          (n == HOLD - 1 && rst_out_n !== NS'(0)) || (n == HOLD && rst_out_n !== NS'(1))) begin
        errors++;
        $display("FAIL hold_glitch n=%0d got=%b want=%b saved_count=%0d", n, got_vec(), exp_vec(), saved);
      end
    end
  endtask

  task automatic test_abort_mid_release();
    logic [CW-1:0] saved;
    logic [NS-1:0] r;
    int guard = 0;
    while (m_t != HOLD + GAP + 2 && guard < 400) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (rst_out_n !== NS'(3)) begin
      errors++;
      $display("FAIL mid_release_pre got=%b want=011 (guard=%0d)", rst_out_n, guard);
    end
    saved = reset_count;
    sys_reset = 1'b1;
    for (int i = 0; i < int'(PULSE); i++) @(negedge clk);
    sys_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rst_out_n !== '0 || ready !== 1'b0 || reset_count !== CW'(saved + 1)) begin
      errors++;
      $display("FAIL mid_release_abort got=%b/%b/%0d want 000/0/%0d", rst_out_n, ready, reset_count, saved + 1);
    end
    for (int n = 0; n < int'(FULL) + 3; n++) begin
      @(negedge clk);
      r = rst_out_n;
      checks++;
      if (got_vec() !== exp_vec() || (r & (r + 1'b1)) !== '0) begin
        errors++;
        $display("FAIL mid_release_seq n=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    for (int a = 0; a < 300; a++) begin
      sys_reset = 1'b0;
      for (int i = 0; i < int'(HOLD) + 4; i++) begin
        @(negedge clk);
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL saturate a=%0d i=%0d got=%b want=%b", a, i, got_vec(), exp_vec());
        end
      end
      sys_reset = 1'b1;
      for (int i = 0; i < int'(PULSE); i++) @(negedge clk);
    end
    sys_reset = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (reset_count !== CW'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturate_final got=%0d want=%0d", reset_count, CNT_MAX);
    end
  endtask

  task automatic test_rst_mid_release();
    int guard = 0;
    sys_reset = 1'b0;
    while (m_t != HOLD + 2 && guard < 400) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (rst_out_n !== NS'(1)) begin
      errors++;
      $display("FAIL rst_mid_pre got=%b want=001 (guard=%0d)", rst_out_n, guard);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (rst_out_n !== '0 || ready !== 1'b0 || reset_count !== '0) begin
      errors++;
      $display("FAIL rst_mid got=%b/%b/%0d want 000/0/0", rst_out_n, ready, reset_count);
    end
  endtask

  task automatic test_random();
    int unsigned lo, hi;
    for (int s = 0; s < 120; s++) begin
      lo = $urandom_range(0, FULL + 8);
      hi = $urandom_range(1, 6);
      if ($urandom_range(0, 19) == 0) rst_n = 1'b0;
      sys_reset = 1'b0;
      for (int unsigned i = 0; i < lo + hi; i++) begin
        if (i == lo) sys_reset = 1'b1;
        if (i == 1) rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random s=%0d i=%0d got=%b want=%b", s, i, got_vec(), exp_vec());
        end
      end
      rst_n = 1'b1;
    end
    sys_reset = 1'b0;
  endtask

`ifdef RSTSEQ_DEBOUNCE_EN
  task automatic test_debounce();
    logic [CW-1:0] saved;
    rst_n = 1'b0; sys_reset = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(FULL) + 3; i++) @(negedge clk);
    saved = reset_count;
    sys_reset = 1'b1;
    for (int i = 0; i < int'(DEB) - 1; i++) @(negedge clk);
    sys_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (rst_out_n !== '1 || ready !== 1'b1 || reset_count !== saved || got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL debounce_short i=%0d got=%b want=%b", i, got_vec(), exp_vec());
      end
    end
    sys_reset = 1'b1;
    for (int i = 0; i < int'(DEB); i++) @(negedge clk);
    sys_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rst_out_n !== '0 || ready !== 1'b0 || reset_count !== CW'(saved + 1)) begin
      errors++;
      $display("FAIL debounce_long got=%b/%b/%0d want 000/0/%0d", rst_out_n, ready, reset_count, saved + 1);
    end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_startup();
    test_run_pulse();
    test_hold_glitch();
    test_abort_mid_release();
    test_saturate();
    test_rst_mid_release();
    test_random();
`ifdef RSTSEQ_DEBOUNCE_EN
    test_debounce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
